seg_scan_driver: RTL

//   Parametrised N-digit multiplexed 7-segment scan driver. Replaces fixed per-design scan logic.

---
 rtl/seg_scan_driver.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: N-digit multiplexed 7-segment scan driver.
// Each digit owns a DIV-cycle slot that opens with BLANK all-off cycles to
// suppress ghosting. Display data is double-buffered: LOAD fills a staging
// copy, which is moved to the active copy only on the last cycle of a frame,
// so a frame never mixes old and new data. All pin outputs are active-low and
// registered, lagging the scan counters by one cycle. o_frame_tick is
// registered alongside them, so it marks the first output cycle of digit 0.
module seg_scan_driver #(
   parameter int N_DIGITS  = 4,
   parameter int DIV       = 100000,
   parameter int BLANK     = 16,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_load,
   input  logic [4*N_DIGITS-1:0]   i_digits,
   input  logic [7*N_DIGITS-1:0]   i_raw,
   input  logic                    i_raw_mode,
   input  logic [N_DIGITS-1:0]     i_dp,
   input  logic [N_DIGITS-1:0]     i_en_mask,
   input  logic [N_DIGITS-1:0]     i_blink_mask,
   output logic [7:0]              o_seg,
   output logic [N_DIGITS-1:0]     o_an,
   output logic                    o_frame_tick,
   output logic                    o_pending
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
   localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
   localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

   // Scan position and blink state
   logic [CW-1:0]           r_cnt;
   logic [IW-1:0]           r_idx;
   logic [BW-1:0]           r_blink_cnt;
   logic                    r_phase;

   // Staging copy, written by LOAD
   logic [4*N_DIGITS-1:0]   r_stg_digits;
   logic [7*N_DIGITS-1:0]   r_stg_raw;
   logic                    r_stg_raw_mode;
   logic [N_DIGITS-1:0]     r_stg_dp;
   logic [N_DIGITS-1:0]     r_stg_en;
   logic [N_DIGITS-1:0]     r_stg_blink;

   // Active copy, the one actually being displayed
   logic [4*N_DIGITS-1:0]   r_act_digits;
   logic [7*N_DIGITS-1:0]   r_act_raw;
   logic                    r_act_raw_mode;
   logic [N_DIGITS-1:0]     r_act_dp;
   logic [N_DIGITS-1:0]     r_act_en;
   logic [N_DIGITS-1:0]     r_act_blink;

   logic                    r_pending;
   logic [7:0]              r_seg;
   logic [N_DIGITS-1:0]     r_an;
   logic                    r_frame_tick;

   logic                    w_slot_end;
   logic                    w_boundary;
   logic                    w_blank;
   logic [3:0]              w_nibble;
   logic [6:0]              w_raw_pat;
   logic                    w_dp;
   logic                    w_en;
   logic                    w_blink;
   logic [N_DIGITS-1:0]     w_an_on;
   logic [6:0]              w_pattern;
   logic                    w_lit;

   // Hex nibble to active-low gfedcba
   function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'b1000000;
         4'h1:    pat = 7'b1111001;
         4'h2:    pat = 7'b0100100;
         4'h3:    pat = 7'b0110000;
         4'h4:    pat = 7'b0011001;
         4'h5:    pat = 7'b0010010;
         4'h6:    pat = 7'b0000010;
         4'h7:    pat = 7'b1111000;
         4'h8:    pat = 7'b0000000;
         4'h9:    pat = 7'b0010000;
         4'hA:    pat = 7'b0001000;
         4'hB:    pat = 7'b0000011;
         4'hC:    pat = 7'b1000110;
         4'hD:    pat = 7'b0100001;
         4'hE:    pat = 7'b0000110;
         default: pat = 7'b0001110;
      endcase
      return pat;
   endfunction

   assign w_slot_end = (r_cnt == CNT_MAX);
   assign w_boundary = w_slot_end && (r_idx == IDX_MAX);
   assign w_blank    = (r_cnt < BLANK_C);

   // Slot counter and digit index; a frame is exactly N_DIGITS*DIV cycles
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_slot_end) begin
         r_cnt <= '0;
         r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Free-running blink timer, phase flips each time it wraps
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (r_blink_cnt == BLK_MAX) begin
         r_blink_cnt <= '0;
         r_phase     <= ~r_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   // Double buffer: LOAD fills staging, the frame boundary publishes it.
   // A LOAD on the boundary itself also refreshes staging so the next
   // boundary copy does not bring back stale data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stg_digits   <= '0;
         r_stg_raw      <= '0;
         r_stg_raw_mode <= 1'b0;
         r_stg_dp       <= '0;
         r_stg_en       <= '0;
         r_stg_blink    <= '0;
         r_act_digits   <= '0;
         r_act_raw      <= '0;
         r_act_raw_mode <= 1'b0;
         r_act_dp       <= '0;
         r_act_en       <= '0;
         r_act_blink    <= '0;
         r_pending      <= 1'b0;
      end else if (w_boundary) begin
         if (i_load) begin
            r_stg_digits   <= i_digits;
            r_stg_raw      <= i_raw;
            r_stg_raw_mode <= i_raw_mode;
            r_stg_dp       <= i_dp;
            r_stg_en       <= i_en_mask;
            r_stg_blink    <= i_blink_mask;
            r_act_digits   <= i_digits;
            r_act_raw      <= i_raw;
            r_act_raw_mode <= i_raw_mode;
            r_act_dp       <= i_dp;
            r_act_en       <= i_en_mask;
            r_act_blink    <= i_blink_mask;
         end else begin
            r_act_digits   <= r_stg_digits;
            r_act_raw      <= r_stg_raw;
            r_act_raw_mode <= r_stg_raw_mode;
            r_act_dp       <= r_stg_dp;
            r_act_en       <= r_stg_en;
            r_act_blink    <= r_stg_blink;
         end
         r_pending <= 1'b0;
      end else if (i_load) begin
         r_stg_digits   <= i_digits;
         r_stg_raw      <= i_raw;
         r_stg_raw_mode <= i_raw_mode;
         r_stg_dp       <= i_dp;
         r_stg_en       <= i_en_mask;
         r_stg_blink    <= i_blink_mask;
         r_pending      <= 1'b1;
      end
   end

   // Pick the active data for the digit currently being scanned
   always_comb begin
      w_nibble  = '0;
      w_raw_pat = '1;
      w_dp      = 1'b0;
      w_en      = 1'b0;
      w_blink   = 1'b0;
      w_an_on   = '1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_nibble   = r_act_digits[4*i +: 4];
            w_raw_pat  = r_act_raw[7*i +: 7];
            w_dp       = r_act_dp[i];
            w_en       = r_act_en[i];
            w_blink    = r_act_blink[i];
            w_an_on[i] = 1'b0;
         end
      end
   end

   assign w_pattern = r_act_raw_mode ? w_raw_pat : hexToSeg(w_nibble);
   assign w_lit     = !w_blank && w_en && !(w_blink && r_phase);

   // Registered pin drive: one anode at most, never during the blank gap
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_seg        <= 8'hFF;
         r_an         <= '1;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= (r_cnt == '0) && (r_idx == '0);
         if (w_lit) begin
            r_an  <= w_an_on;
            r_seg <= {~w_dp, w_pattern};
         end else begin
            r_an  <= '1;
            r_seg <= 8'hFF;
         end
      end
   end

   assign o_seg        = r_seg;
   assign o_an         = r_an;
   assign o_frame_tick = r_frame_tick;
   assign o_pending    = r_pending;

endmodule
